tea_lane_pool_scheduler: RTL and testbench

//  Round-robin dispatcher for NUM_LANES iterative TEA cores, with in-order result return.

---
 rtl/tea_lane_pool_scheduler_pkg.sv | 10 +
 rtl/tea_lane_pool_scheduler_lane.sv | 81 ++++++++
 rtl/tea_lane_pool_scheduler.sv | 74 +++++++
 tb/tb_tea_lane_pool_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tea_lane_pool_scheduler_pkg.sv
// Shared TEA constants, lane state encoding and the decrypt sum seed.
package tea_pkg;
    localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} lane_state_e;

    function automatic logic [31:0] tea_sum_init(input logic [31:0] rounds);
        return TEA_DELTA * rounds;
    endfunction
endpackage

// File: rtl/tea_lane_pool_scheduler_lane.sv
// One iterative TEA lane: one round per enabled clock, result held until collected.
module tea_lane_iter
    import tea_pkg::*;
#(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         lane_ena,
    input  logic         start,
    input  logic         decrypt,
    input  logic [63:0]  block,
    input  logic [127:0] key,
    input  logic         collect,
    output logic         done,
    output logic [63:0]  result
);
    localparam int RC_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    lane_state_e      state_q, state_d;
    logic [RC_W-1:0]  cnt_q;
    logic [31:0]      v0_q, v1_q, sum_q;
    logic [127:0]     key_q;
    logic             dec_q;
    logic [31:0]      k0, k1, k2, k3;
    logic [31:0]      sum_e, v0_e, v1_e, v0_d, v1_d;

    assign {k0, k1, k2, k3} = key_q;

    // Encrypt pre-adds delta; decrypt uses the current sum and steps it down afterwards.
    assign sum_e = sum_q + TEA_DELTA;
    assign v0_e  = v0_q + (((v1_q << 4) + k0) ^ (v1_q + sum_e) ^ ((v1_q >> 5) + k1));
    assign v1_e  = v1_q + (((v0_e << 4) + k2) ^ (v0_e + sum_e) ^ ((v0_e >> 5) + k3));
    assign v1_d  = v1_q - (((v0_q << 4) + k2) ^ (v0_q + sum_q) ^ ((v0_q >> 5) + k3));
    assign v0_d  = v0_q - (((v1_d << 4) + k0) ^ (v1_d + sum_q) ^ ((v1_d >> 5) + k1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt_q == RC_W'(ROUNDS - 1)) state_d = DONE;
            DONE:    if (collect) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            v0_q    <= '0;
            v1_q    <= '0;
            sum_q   <= '0;
            key_q   <= '0;
            dec_q   <= 1'b0;
        end else if (lane_ena) begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                {v0_q, v1_q} <= block;
                key_q        <= key;
                dec_q        <= decrypt;
                cnt_q        <= '0;
                sum_q        <= decrypt ? tea_sum_init(32'(ROUNDS)) : 32'h0;
            end else if (state_q == RUN) begin
                cnt_q <= cnt_q + 1'b1;
                if (dec_q) begin
                    v0_q  <= v0_d;
                    v1_q  <= v1_d;
                    sum_q <= sum_q - TEA_DELTA;
                end else begin
                    v0_q  <= v0_e;
                    v1_q  <= v1_e;
                    sum_q <= sum_e;
                end
            end
        end
    end

    assign done   = (state_q == DONE);
    assign result = {v0_q, v1_q};
endmodule

// File: rtl/tea_lane_pool_scheduler.sv
// Round-robin pool of iterative TEA lanes; results return in acceptance order.
module tea_lane_pool_scheduler
    import tea_pkg::*;
#(
    parameter  int NUM_LANES = 8,
    parameter  int ROUNDS    = 32,
    localparam int CNT_W     = $clog2(NUM_LANES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_block,
    input  logic [127:0]     in_key,
    input  logic             in_decrypt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_block,
    output logic [CNT_W-1:0] inflight,
    output logic             busy
);
    localparam int PTR_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [PTR_W-1:0]     disp_ptr, coll_ptr;
    logic [CNT_W-1:0]     inflight_q;
    logic [NUM_LANES-1:0] done, start, collect;
    logic [63:0]          result [NUM_LANES];
    logic                 accept, deliver;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_LANES - 1)) ? '0 : p + 1'b1;
    endfunction

    // Both pointers rotate identically, so the dispatch lane is free exactly when not full.
    assign in_ready  = ena & ~rst & (inflight_q != CNT_W'(NUM_LANES));
    assign out_valid = ena & done[coll_ptr];
    assign out_block = out_valid ? result[coll_ptr] : 64'h0;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;
    assign inflight  = inflight_q;
    assign busy      = (inflight_q != '0);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign start[i]   = accept & (disp_ptr == PTR_W'(i));
        assign collect[i] = deliver & (coll_ptr == PTR_W'(i));

        tea_lane_iter #(.ROUNDS(ROUNDS)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .lane_ena (ena),
            .start    (start[i]),
            .decrypt  (in_decrypt),
            .block    (in_block),
            .key      (in_key),
            .collect  (collect[i]),
            .done     (done[i]),
            .result   (result[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_ptr   <= '0;
            coll_ptr   <= '0;
            inflight_q <= '0;
        end else begin
            if (accept)  disp_ptr <= ptr_next(disp_ptr);
            if (deliver) coll_ptr <= ptr_next(coll_ptr);
            if (accept && !deliver)      inflight_q <= inflight_q + 1'b1;
            else if (deliver && !accept) inflight_q <= inflight_q - 1'b1;
        end
    end
endmodule

// File: tb/tb_tea_lane_pool_scheduler.sv
// Bench for the TEA lane pool: vector table, corner sequences and a queue-based reference.
module tb_tea_lane_pool_scheduler;
    localparam int NL = 8;
    localparam int R  = 32;
    localparam int CW = $clog2(NL + 1);
    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [63:0]   in_block = '0;
    logic [127:0]  in_key = '0;
    logic          in_decrypt = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_block;
    logic [CW-1:0] inflight;
    logic          busy;

    tea_lane_pool_scheduler #(.NUM_LANES(NL), .ROUNDS(R)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .in_key(in_key), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          left;
    } ent_t;

    typedef struct {
        bit           dec;
        logic [127:0] key;
        logic [63:0]  blk;
        logic [63:0]  exp;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          tick_n = 0;
    bit          acc, del, obs_ov;
    logic [63:0] obs_blk;
    ent_t        q[$];

    // Plain textbook TEA over all rounds.
    function automatic logic [63:0] tea_ref(bit dec, logic [127:0] k, logic [63:0] b);
        logic [31:0] y, z, s, k0, k1, k2, k3;
        {k0, k1, k2, k3} = k;
        {y, z} = b;
        if (!dec) begin
            s = 0;
            for (int i = 0; i < R; i++) begin
                s = s + DELTA;
                y = y + (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
                z = z + (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
            end
        end else begin
            s = DELTA * 32'(R);
            for (int i = 0; i < R; i++) begin
                z = z - (((y << 4) + k2) ^ (y + s) ^ ((y >> 5) + k3));
                y = y - (((z << 4) + k0) ^ (z + s) ^ ((z >> 5) + k1));
                s = s - DELTA;
            end
        end
        return {y, z};
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
        end
    endtask

    task automatic rand_in();
        in_block   = {$urandom, $urandom};
        in_key     = {$urandom, $urandom, $urandom, $urandom};
        in_decrypt = 1'($urandom % 2);
    endtask

    // One cycle: compare against the model, clock, then update the model.
    task automatic tick();
        bit eir, eov;
        logic [63:0] eb;
        ent_t e;
        #1;
        eir = ena && (q.size() < NL);
        eov = ena && (q.size() > 0) && (q[0].left == 0);
        eb  = eov ? q[0].res : 64'h0;
        chk("in_ready", 64'(in_ready), 64'(eir));
        chk("out_valid", 64'(out_valid), 64'(eov));
        chk("out_block", out_block, eb);
        chk("inflight", 64'(inflight), 64'(q.size()));
        chk("busy", 64'(busy), 64'(q.size() != 0));
        obs_ov  = out_valid;
        obs_blk = out_block;
        acc = in_valid && eir;
        del = eov && out_ready;
        e.res  = tea_ref(in_decrypt, in_key, in_block);
        e.left = R;
        @(posedge clk);
        if (ena)
            for (int i = 0; i < q.size(); i++)
                if (q[i].left > 0) q[i].left = q[i].left - 1;
        if (del) void'(q.pop_front());
        if (acc) q.push_back(e);
        #1;
        tick_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ena = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_block", out_block, 64'h0);
        @(posedge clk);
        #1;
        chk("rst_inflight", 64'(inflight), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        q.delete();
        rst = 1'b0;
    endtask

    task automatic run_one(input bit dec, input logic [127:0] key, input logic [63:0] blk,
                           output logic [63:0] res, output int lat);
        int a, k;
        a = -1;
        lat = -1;
        res = '0;
        in_valid = 1'b1;
        in_decrypt = dec;
        in_key = key;
        in_block = blk;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && a < 0; i++) begin
            k = tick_n;
            tick();
            if (acc) a = k;
        end
        in_valid = 1'b0;
        chk("accept_seen", 64'(a >= 0), 64'h1);
        for (int i = 0; i < 200 && lat < 0 && a >= 0; i++) begin
            k = tick_n;
            tick();
            if (obs_ov) begin
                lat = k - a - 1;
                res = obs_blk;
            end
        end
    endtask

    initial begin
        vec_t        tv[4];
        logic [63:0] r, c, p, held;
        logic [127:0] kk;
        int          lat, n, k, nd;
        int          at[NL + 4];
        int          dt[NL];
        int          ov_t[2];

        tv[0] = '{0, 128'h0, 64'h0, 64'h41EA3A0A94BAA940};
        tv[1] = '{1, 128'h0, 64'h41EA3A0A94BAA940, 64'h0};
        for (int i = 2; i < 4; i++) begin
            tv[i].dec = bit'(i - 2);
            tv[i].key = {$urandom, $urandom, $urandom, $urandom};
            tv[i].blk = {$urandom, $urandom};
            tv[i].exp = tea_ref(tv[i].dec, tv[i].key, tv[i].blk);
        end

        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_one(tv[i].dec, tv[i].key, tv[i].blk, r, lat);
            chk($sformatf("vec%0d_result", i), r, tv[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(R));
        end

        for (int i = 0; i < 3; i++) begin
            kk = {$urandom, $urandom, $urandom, $urandom};
            p  = {$urandom, $urandom};
            run_one(1'b0, kk, p, c, lat);
            run_one(1'b1, kk, c, r, lat);
            chk($sformatf("roundtrip%0d", i), r, p);
        end

        // Burst beyond capacity with free-flowing output.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_in();
        n = 0;
        for (int i = 0; i < 600 && (n < NL + 4 || q.size() > 0); i++) begin
            k = tick_n;
            tick();
            if (acc) begin
                at[n] = k;
                n++;
                if (n == NL + 4) in_valid = 1'b0;
                else rand_in();
            end
        end
        chk("burst_count", 64'(n), 64'(NL + 4));
        for (int i = 1; i < NL; i++)
            chk($sformatf("burst_gap%0d", i), 64'(at[i] - at[0]), 64'(i));
        chk("burst_refill", 64'(at[NL] - at[0]), 64'(R + 2));

        // Full pool, output stalled for 100 cycles, then released.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_in();
        n = 0;
        for (int i = 0; i < 100 && n < NL; i++) begin
            tick();
            if (acc) begin
                n++;
                rand_in();
            end
        end
        for (int i = 0; i < R + NL + 4; i++) tick();
        held = obs_blk;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("stall_hold", obs_blk, held);
        end
        chk("stall_inflight", 64'(inflight), 64'(NL));
        chk("stall_in_ready", 64'(in_ready), 64'h0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        nd = 0;
        for (int i = 0; i < NL + 20 && nd < NL; i++) begin
            k = tick_n;
            tick();
            if (del) begin
                dt[nd] = k;
                nd++;
            end
        end
        chk("release_count", 64'(nd), 64'(NL));
        for (int i = 1; i < nd; i++)
            chk($sformatf("release_gap%0d", i), 64'(dt[i] - dt[i-1]), 64'h1);

        // Freeze for 10 cycles mid-run.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_in();
        n = 0;
        for (int i = 0; i < 10 && n < 2; i++) begin
            k = tick_n;
            tick();
            if (acc) begin
                at[n] = k;
                n++;
                rand_in();
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        ena = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        ena = 1'b1;
        nd = 0;
        for (int i = 0; i < 100 && nd < 2; i++) begin
            k = tick_n;
            tick();
            if (obs_ov) begin
                ov_t[nd] = k;
                nd++;
            end
        end
        chk("freeze_count", 64'(nd), 64'h2);
        for (int i = 0; i < nd && i < n; i++)
            chk($sformatf("freeze_lat%0d", i), 64'(ov_t[i] - at[i] - 1), 64'(R + 10));

        // Reset in the middle of a burst, then restart cleanly.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_in();
        for (int i = 0; i < 5; i++) begin
            tick();
            if (acc) rand_in();
        end
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        rand_in();
        n = 0;
        for (int i = 0; i < 200 && (n < 3 || q.size() > 0); i++) begin
            tick();
            if (acc) begin
                n++;
                if (n == 3) in_valid = 1'b0;
                else rand_in();
            end
        end
        chk("post_reset_count", 64'(n), 64'h3);

        // Random traffic against the reference queue.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ena       = ($urandom % 10) != 0;
            in_valid  = ($urandom % 2) != 0;
            out_ready = ($urandom % 10) < 6;
            rand_in();
            tick();
        end
        ena = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && q.size() > 0; i++) tick();
        chk("drain_inflight", 64'(inflight), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
